ttes_mode_counter: RTL

Parametrised multi-mode counter; the next-generation counter core of the ttes tile, replacing the fixed 4-bit free-running counter. Adds configurable width, up/down counting, wrap or saturate modes, synchronous load, a compare-match flag and a terminal-count pulse, with an optional clock-enable prescaler. It sits between the tile's input pins (mode/control) and the output pins (count display).

---
 rtl/ttes_mode_counter_if.sv | 32 +++
 rtl/ttes_mode_counter.sv | 94 +++++++++
 2 files changed

// File: rtl/ttes_mode_counter_if.sv
// ttes_mode_counter_if: control/status bundle between the tile pins and the counter core.
// Latency: none (wires only); the core registers every output it drives here.
// Backpressure: none; en is the only qualifier. Optional div field under TTES_COUNTER_PRESCALER_EN.
interface ttes_mode_counter_if #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
);
  logic             en;
  logic             dir;
  logic             sat;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cmp_val;
`ifdef TTES_COUNTER_PRESCALER_EN
  logic [PRESCALE_W-1:0] div;
`endif
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             match;

`ifdef TTES_COUNTER_PRESCALER_EN
  modport master (output en, dir, sat, load, load_val, cmp_val, div,
                  input  count, tc, match);
  modport slave  (input  en, dir, sat, load, load_val, cmp_val, div,
                  output count, tc, match);
`else
  modport master (output en, dir, sat, load, load_val, cmp_val,
                  input  count, tc, match);
  modport slave  (input  en, dir, sat, load, load_val, cmp_val,
                  output count, tc, match);
`endif
endinterface

// File: rtl/ttes_mode_counter.sv
// ttes_mode_counter: up/down, wrap/saturate counter with load, compare-match and terminal-count pulse.
// Latency: 1 cycle; count, tc and match all change on the edge that samples load/tick.
// Backpressure: none; en=0 freezes counter and prescaler. Prescaler under TTES_COUNTER_PRESCALER_EN.
module ttes_mode_counter #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input logic                 clk,
  input logic                 rst,
  ttes_mode_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_q;
  logic             tc_nxt;
  logic             match_q;
  logic             tick;

`ifdef TTES_COUNTER_PRESCALER_EN
  localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] pre_q;
  logic [PRESCALE_W-1:0] pre_nxt;

  // Prescaler phase: a load restarts the phase; en=0 keeps it where it is.
  always_comb begin
    tick    = bus.en && (pre_q == bus.div);
    pre_nxt = pre_q;
    if (bus.load) begin
      pre_nxt = '0;
    end else if (bus.en) begin
      pre_nxt = (pre_q == bus.div) ? '0 : pre_q + PRE_ONE;
    end
  end

  // Prescaler register; a shrunk div lets pre run through its full range.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_nxt;
    end
  end
`else
  assign tick = bus.en;
`endif

  // Next count and boundary pulse; load beats tick and suppresses tc.
  always_comb begin
    count_nxt = count_q;
    tc_nxt    = 1'b0;
    if (bus.load) begin
      count_nxt = bus.load_val;
    end else if (tick) begin
      if (bus.dir) begin
        if (count_q == ALL_ONES) begin
          tc_nxt    = 1'b1;
          count_nxt = bus.sat ? count_q : '0;
        end else begin
          count_nxt = count_q + ONE;
        end
      end else begin
        if (count_q == '0) begin
          tc_nxt    = 1'b1;
          count_nxt = bus.sat ? count_q : ALL_ONES;
        end else begin
          count_nxt = count_q - ONE;
        end
      end
    end
  end

  // State registers; match is taken from next-state so it lines up with count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      match_q <= 1'b0;
    end else begin
      count_q <= count_nxt;
      tc_q    <= tc_nxt;
      match_q <= (count_nxt == bus.cmp_val);
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.match = match_q;

endmodule
